// File: rtl/ccc_handler.sv
// HDR-DDR CCC engine: frames one broadcast or direct CCC descriptor, drives the
// TX/RX serializers, SCL staller and counters, and reports completion status.
module ccc_handler (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst,
    input  logic        i_engine_en,
    input  logic [5:0]  i_bitcnt_number,
    input  logic        i_tx_mode_done,
    input  logic        i_rx_mode_done,
    input  logic        i_rx_first_pre,
    input  logic        i_rx_second_pre,
    input  logic        i_rx_error,
    input  logic        i_sclstall_stall_done,
    input  logic        i_frmcnt_last_frame,
    input  logic        i_regf_RnW,
    input  logic [2:0]  i_regf_CMD_ATTR,
    input  logic [7:0]  i_regf_CMD,
    input  logic [4:0]  i_regf_DEV_INDEX,
    input  logic        i_regf_TOC,
    input  logic        i_regf_WROC,
    input  logic [2:0]  i_regf_DTT,
    input  logic        i_regf_DBP,
    input  logic        i_regf_SRE,
    output logic        o_sclstall_en,
    output logic [3:0]  o_sclstall_code,
    output logic        o_tx_en,
    output logic [3:0]  o_tx_mode,
    output logic        o_rx_en,
    output logic [2:0]  o_rx_mode,
    output logic        o_bitcnt_en,
    output logic        o_bitcnt_err_rst,
    output logic        o_frmcnt_en,
    output logic        o_sdahand_pp_od,
    output logic        o_regf_wr_en,
    output logic        o_regf_rd_en,
    output logic [15:0] o_regf_addr,
    output logic        o_engine_done,
    output logic [7:0]  o_txrx_addr_ccc,
    output logic        o_engine_odd,
    output logic [3:0]  o_regf_ERR_STATUS
);

    typedef enum logic [4:0] {
        S_IDLE, S_PRE_CMD, S_RNW, S_RESERVED, S_ADDR, S_CMD_PAR,
        S_CCC_PRE, S_CCC_VAL, S_DEF_BYTE, S_CCC_PAR,
        S_PL_PRE, S_PL_DATA, S_PL_PAR,
        S_RX_PRE, S_RX_DATA, S_RX_CRC,
        S_CRC_PRE, S_CRC_TOKEN, S_CRC_VALUE,
        S_STALL, S_RESTART, S_EXIT, S_ERROR, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cmd_q;
    logic [2:0]  attr_q;
    logic [2:0]  dtt_q;
    logic [4:0]  dev_q;
    logic        rnw_q, toc_q, wroc_q, dbp_q, sre_q, odd_q;
    logic        second_q, second_d;
    logic [3:0]  err_q, err_d;
    logic [15:0] idx_q, idx_d;
    logic        first_q;

    logic        direct;
    logic        skip_payload;
    logic [6:0]  dev_addr;
    logic [7:0]  addr_byte;
    state_t      after_header;

    assign direct       = cmd_q[7];
    assign skip_payload = (dtt_q == 3'd0) && (attr_q == 3'd1);
    // Target address is the device index; the low bit carries odd parity over it.
    assign dev_addr     = {2'b00, dev_q};
    assign addr_byte    = {dev_addr, ~^dev_addr};
    assign after_header = skip_payload ? S_CRC_PRE : S_PL_PRE;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q  <= S_IDLE;
            second_q <= 1'b0;
            err_q    <= 4'd0;
            idx_q    <= 16'd0;
            first_q  <= 1'b0;
            cmd_q    <= 8'd0;
            attr_q   <= 3'd0;
            dtt_q    <= 3'd0;
            dev_q    <= 5'd0;
            rnw_q    <= 1'b0;
            toc_q    <= 1'b0;
            wroc_q   <= 1'b0;
            dbp_q    <= 1'b0;
            sre_q    <= 1'b0;
            odd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            second_q <= second_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            first_q  <= (state_d != state_q);
            if (state_q == S_IDLE && i_engine_en) begin
                cmd_q  <= i_regf_CMD;
                attr_q <= i_regf_CMD_ATTR;
                dtt_q  <= i_regf_DTT;
                dev_q  <= i_regf_DEV_INDEX;
                rnw_q  <= i_regf_RnW;
                toc_q  <= i_regf_TOC;
                wroc_q <= i_regf_WROC;
                dbp_q  <= i_regf_DBP;
                sre_q  <= i_regf_SRE;
                odd_q  <= i_regf_DTT[0];
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        second_d         = second_q;
        err_d            = err_q;
        idx_d            = idx_q;
        o_sclstall_en    = 1'b0;
        o_sclstall_code  = 4'd0;
        o_tx_en          = 1'b0;
        o_tx_mode        = 4'd0;
        o_rx_en          = 1'b0;
        o_rx_mode        = 3'd0;
        o_bitcnt_err_rst = 1'b0;
        o_frmcnt_en      = 1'b0;
        o_regf_wr_en     = 1'b0;
        o_regf_rd_en     = 1'b0;
        o_engine_done    = 1'b0;
        o_txrx_addr_ccc  = 8'd0;
        o_bitcnt_en      = (state_q != S_IDLE);
        o_sdahand_pp_od  = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (i_engine_en) begin
                    state_d  = S_PRE_CMD;
                    second_d = 1'b0;
                    err_d    = 4'd0;
                end
            end
            S_PRE_CMD: begin
                o_tx_en = 1'b1; o_tx_mode = 4'd0;
                if (i_tx_mode_done) state_d = S_RNW;
            end
            S_RNW: begin
                o_tx_en = 1'b1; o_tx_mode = 4'd1;
                o_txrx_addr_ccc = {7'd0, second_q & rnw_q};
                if (i_tx_mode_done) state_d = S_RESERVED;
            end
            S_RESERVED: begin
                o_tx_en = 1'b1; o_tx_mode = 4'd2;
                if (i_tx_mode_done) state_d = S_ADDR;
            end
            S_ADDR: begin
                o_tx_en = 1'b1; o_tx_mode = 4'd3;
                o_txrx_addr_ccc = second_q ? addr_byte : 8'h7E;
                if (i_tx_mode_done) state_d = S_CMD_PAR;
            end
            S_CMD_PAR: begin
                o_tx_en = 1'b1; o_tx_mode = 4'd4;
                if (i_tx_mode_done) begin
                    if (!second_q)  state_d = S_CCC_PRE;
                    else if (rnw_q) state_d = S_RX_PRE;
                    else            state_d = after_header;
                end
            end
            S_CCC_PRE: begin
                o_tx_en = 1'b1; o_tx_mode = 4'd5;
                if (i_tx_mode_done) state_d = S_CCC_VAL;
            end
            S_CCC_VAL: begin
                o_tx_en = 1'b1; o_tx_mode = 4'd3;
                o_txrx_addr_ccc = cmd_q;
                if (i_tx_mode_done) state_d = dbp_q ? S_DEF_BYTE : S_CCC_PAR;
            end
            S_DEF_BYTE: begin
                o_tx_en = 1'b1; o_tx_mode = 4'd6;
                if (i_tx_mode_done) state_d = S_CCC_PAR;
            end
            S_CCC_PAR: begin
                o_tx_en = 1'b1; o_tx_mode = 4'd4;
                if (i_tx_mode_done) state_d = direct ? S_STALL : after_header;
            end
            S_PL_PRE: begin
                o_tx_en = 1'b1; o_tx_mode = 4'd5; o_frmcnt_en = 1'b1;
                if (i_tx_mode_done) state_d = S_PL_DATA;
            end
            S_PL_DATA: begin
                o_tx_en = 1'b1; o_tx_mode = 4'd6; o_frmcnt_en = 1'b1;
                o_regf_rd_en = first_q;
                if (i_tx_mode_done) state_d = S_PL_PAR;
            end
            S_PL_PAR: begin
                o_tx_en = 1'b1; o_tx_mode = 4'd4; o_frmcnt_en = 1'b1;
                if (i_tx_mode_done) begin
                    idx_d   = idx_q + 16'd1;
                    state_d = i_frmcnt_last_frame ? S_CRC_PRE : S_PL_PRE;
                end
            end
            S_RX_PRE: begin
                o_rx_en = 1'b1; o_rx_mode = 3'd0;
                if (i_rx_error) begin
                    err_d = 4'd1; state_d = S_ERROR;
                end else if (i_rx_mode_done) begin
                    if (i_rx_first_pre) state_d = S_RX_DATA;
                    else begin
                        err_d = 4'd4; state_d = S_EXIT;
                    end
                end
            end
            S_RX_DATA: begin
                o_rx_en = 1'b1; o_rx_mode = 3'd1;
                if (i_rx_error) begin
                    err_d = 4'd1; state_d = S_ERROR;
                end else if (i_rx_mode_done) begin
                    o_regf_wr_en = 1'b1;
                    idx_d        = idx_q + 16'd1;
                    // A target ending the read before the last frame is a short read.
                    if (i_frmcnt_last_frame)  state_d = S_RX_CRC;
                    else if (i_rx_second_pre) state_d = S_RX_DATA;
                    else begin
                        if (sre_q) err_d = 4'd5;
                        state_d = S_RX_CRC;
                    end
                end
            end
            S_RX_CRC: begin
                o_rx_en = 1'b1; o_rx_mode = 3'd2;
                if (i_rx_error) begin
                    err_d = 4'd1; state_d = S_ERROR;
                end else if (i_rx_mode_done) state_d = S_STALL;
            end
            S_CRC_PRE: begin
                o_tx_en = 1'b1; o_tx_mode = 4'd7;
                if (i_tx_mode_done) state_d = S_CRC_TOKEN;
            end
            S_CRC_TOKEN: begin
                o_tx_en = 1'b1; o_tx_mode = 4'd8;
                if (i_tx_mode_done) state_d = S_CRC_VALUE;
            end
            S_CRC_VALUE: begin
                o_tx_en = 1'b1; o_tx_mode = 4'd9;
                if (i_tx_mode_done) state_d = S_STALL;
            end
            S_STALL: begin
                o_sclstall_en = 1'b1; o_sclstall_code = 4'd2;
                if (i_sclstall_stall_done) begin
                    if (direct && !second_q) state_d = S_RESTART;
                    else                     state_d = toc_q ? S_EXIT : S_RESTART;
                end
            end
            S_RESTART: begin
                o_tx_en = 1'b1; o_tx_mode = 4'd10;
                if (i_tx_mode_done) begin
                    // The mid-command restart leads into the addressed second word.
                    if (direct && !second_q) begin
                        second_d = 1'b1;
                        state_d  = S_PRE_CMD;
                    end else begin
                        state_d  = S_DONE;
                    end
                end
            end
            S_EXIT: begin
                o_tx_en = 1'b1; o_tx_mode = 4'd11;
                if (i_tx_mode_done) state_d = S_DONE;
            end
            S_ERROR: begin
                if (i_bitcnt_number == 6'd19) begin
                    o_bitcnt_err_rst = 1'b1;
                    state_d          = S_EXIT;
                end
            end
            S_DONE: begin
                o_engine_done = 1'b1;
                o_regf_wr_en  = wroc_q || (err_q != 4'd0);
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && !i_engine_en) state_d = S_IDLE;
        if (state_d == S_IDLE) idx_d = 16'd0;
    end

    assign o_regf_addr       = idx_q;
    assign o_regf_ERR_STATUS = err_q;
    assign o_engine_odd      = odd_q;

endmodule

// File: tb/tb_ccc_handler.sv
// Scoreboard bench for ccc_handler: expected per-cycle output vectors are queued
// before each command and a negedge monitor pops one per active engine cycle.
module tb_ccc_handler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [5:0]  bitcnt = 6'd0;
    logic        first_pre = 1'b1, second_pre = 1'b1, inj_err = 1'b0;
    logic        rnw = 1'b0, toc = 1'b0, wroc = 1'b0, dbp = 1'b0, sre = 1'b0;
    logic [2:0]  attr = 3'd0, dtt = 3'd0;
    logic [7:0]  cmd = 8'd0;
    logic [4:0]  dev = 5'd0;
    logic [15:0] frames = 16'd1;
    logic        rx_err_w, last_w;

    logic        sclstall_en, tx_en, rx_en, bitcnt_en, bitcnt_err_rst, frmcnt_en;
    logic        pp_od, regf_wr_en, regf_rd_en, engine_done, engine_odd;
    logic [3:0]  sclstall_code, tx_mode, err_status;
    logic [2:0]  rx_mode;
    logic [15:0] regf_addr;
    logic [7:0]  addr_ccc;

    int          tests = 0, fails = 0, step = 0;
    string       cur_name = "reset";
    logic [3:0]  cur_err = 4'd0;
    logic        cur_odd = 1'b0;
    logic [37:0] exp_q[$];

    always #10 clk = ~clk;

    // Stimulus models of the RX error source, frame counter and bit counter.
    assign rx_err_w = inj_err && rx_en && (rx_mode == 3'd1);
    assign last_w   = ((regf_addr + 16'd1) >= frames);
    always @(posedge clk) bitcnt <= bitcnt_en ? bitcnt + 6'd1 : 6'd0;

    ccc_handler dut (
        .i_sys_clk(clk), .i_sys_rst(rst_n), .i_engine_en(en),
        .i_bitcnt_number(bitcnt), .i_tx_mode_done(1'b1), .i_rx_mode_done(1'b1),
        .i_rx_first_pre(first_pre), .i_rx_second_pre(second_pre), .i_rx_error(rx_err_w),
        .i_sclstall_stall_done(1'b1), .i_frmcnt_last_frame(last_w),
        .i_regf_RnW(rnw), .i_regf_CMD_ATTR(attr), .i_regf_CMD(cmd),
        .i_regf_DEV_INDEX(dev), .i_regf_TOC(toc), .i_regf_WROC(wroc),
        .i_regf_DTT(dtt), .i_regf_DBP(dbp), .i_regf_SRE(sre),
        .o_sclstall_en(sclstall_en), .o_sclstall_code(sclstall_code),
        .o_tx_en(tx_en), .o_tx_mode(tx_mode), .o_rx_en(rx_en), .o_rx_mode(rx_mode),
        .o_bitcnt_en(bitcnt_en), .o_bitcnt_err_rst(bitcnt_err_rst),
        .o_frmcnt_en(frmcnt_en), .o_sdahand_pp_od(pp_od),
        .o_regf_wr_en(regf_wr_en), .o_regf_rd_en(regf_rd_en), .o_regf_addr(regf_addr),
        .o_engine_done(engine_done), .o_txrx_addr_ccc(addr_ccc),
        .o_engine_odd(engine_odd), .o_regf_ERR_STATUS(err_status)
    );

    function automatic logic [37:0] pack(
        input logic pp, input logic te, input logic [3:0] tm, input logic re,
        input logic [2:0] rm, input logic se, input logic [3:0] sc, input logic fe,
        input logic dn, input logic rd, input logic wr, input logic er,
        input logic [3:0] err, input logic odd, input logic [7:0] b,
        input logic [3:0] idx, input logic hz);
        return {pp, te, tm, re, rm, se, sc, fe, dn, rd, wr, er, err, odd, b, idx, hz};
    endfunction

    task automatic etx(input logic [3:0] m, input logic [7:0] b);
        exp_q.push_back(pack(1, 1, m, 0, 0, 0, 0, 0, 0, 0, 0, 0, cur_err, cur_odd,
                             (m == 4'd3) ? b : 8'd0, 4'd0, 1));
    endtask
    task automatic epl(input logic [3:0] m, input logic [3:0] idx, input logic rd);
        exp_q.push_back(pack(1, 1, m, 0, 0, 0, 0, 1, 0, rd, 0, 0, cur_err, cur_odd,
                             8'd0, (m == 4'd6) ? idx : 4'd0, 1));
    endtask
    task automatic erx(input logic [2:0] m, input logic [3:0] idx, input logic wr);
        exp_q.push_back(pack(1, 0, 0, 1, m, 0, 0, 0, 0, 0, wr, 0, cur_err, cur_odd,
                             8'd0, (m == 3'd1) ? idx : 4'd0, 1));
    endtask
    task automatic estall();
        exp_q.push_back(pack(1, 0, 0, 0, 0, 1, 4'd2, 0, 0, 0, 0, 0, cur_err, cur_odd, 8'd0, 4'd0, 1));
    endtask
    task automatic eerr(input logic erst);
        exp_q.push_back(pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, erst, cur_err, cur_odd, 8'd0, 4'd0, 1));
    endtask
    task automatic edone(input logic wr);
        exp_q.push_back(pack(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, wr, 0, cur_err, cur_odd, 8'd0, 4'd0, 1));
    endtask

    task automatic p_cmd(input logic [7:0] b);
        etx(0, 0); etx(1, 0); etx(2, 0); etx(3, b); etx(4, 0);
    endtask
    task automatic p_ccc(input logic [7:0] c, input logic with_def);
        etx(5, 0); etx(3, c);
        if (with_def) etx(6, 0);
        etx(4, 0);
    endtask
    task automatic p_pl(input int n);
        for (int i = 0; i < n; i++) begin
            epl(5, 0, 0); epl(6, 4'(i), 1); epl(4, 0, 0);
        end
    endtask
    task automatic p_crc();
        etx(7, 0); etx(8, 0); etx(9, 0);
    endtask
    task automatic p_end(input logic t, input logic wr);
        estall(); etx(t ? 4'd11 : 4'd10, 0); edone(wr);
    endtask

    task automatic setup(input string nm, input logic [7:0] c, input logic r,
                         input logic [2:0] a, input logic [2:0] d, input logic t,
                         input logic w, input logic db, input logic [15:0] fr);
        cur_name = nm; cmd = c; rnw = r; attr = a; dtt = d; toc = t; wroc = w;
        dbp = db; frames = fr; cur_err = 4'd0; cur_odd = d[0];
        first_pre = 1'b1; second_pre = 1'b1; inj_err = 1'b0; sre = 1'b0;
    endtask

    task automatic run(input logic scramble);
        logic got;
        got  = 1'b0;
        step = 0;
        @(negedge clk);
        en = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c == 2 && scramble) begin
                cmd = 8'hFF; toc = ~toc; dbp = ~dbp; dtt = ~dtt;
            end
            if (engine_done) begin
                got = 1'b1;
                break;
            end
        end
        en = 1'b0;
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s done_timeout: got no engine_done, required one within 300 cycles", cur_name);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s leftover: got %0d unconsumed expected cycles, required 0", cur_name, exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        logic [37:0] act, exp_v;
        logic        bsel, isel;
        if (bitcnt_en) begin
            bsel = tx_en && (tx_mode == 4'd3);
            isel = (tx_en && tx_mode == 4'd6) || (rx_en && rx_mode == 3'd1);
            act = pack(pp_od, tx_en, tx_mode, rx_en, rx_mode, sclstall_en, sclstall_code,
                       frmcnt_en, engine_done, regf_rd_en, regf_wr_en, bitcnt_err_rst,
                       err_status, engine_odd, bsel ? addr_ccc : 8'd0,
                       isel ? regf_addr[3:0] : 4'd0, regf_addr[15:4] == 12'd0);
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL %s step %0d extra_cycle: got %h, required no active cycle", cur_name, step, act);
            end else begin
                exp_v = exp_q.pop_front();
                if (act !== exp_v) begin
                    fails++;
                    $display("FAIL %s step %0d outputs: got %h required %h", cur_name, step, act, exp_v);
                end
            end
            step++;
        end
    end

    task automatic check_idle(input string nm);
        tests++;
        if ({sclstall_en, sclstall_code, tx_en, tx_mode, rx_en, rx_mode, bitcnt_en,
             bitcnt_err_rst, frmcnt_en, pp_od, regf_wr_en, regf_rd_en, regf_addr,
             engine_done, addr_ccc, engine_odd, err_status} !== '0) begin
            fails++;
            $display("FAIL %s idle_outputs: got nonzero (tx_en=%b mode=%0d addr=%h err=%0d), required all 0",
                     nm, tx_en, tx_mode, regf_addr, err_status);
        end
    endtask

    initial begin
        dev = 5'd5;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("after_reset");

        // Direct write, RESTART at end; address byte for index 5 is 8'h0B.
        setup("dwr_restart", 8'h89, 0, 3'd0, 3'd2, 0, 0, 0, 16'd1);
        p_cmd(8'h7E); p_ccc(8'h89, 0); estall(); etx(10, 0);
        p_cmd(8'h0B); p_pl(1); p_crc(); p_end(0, 0);
        run(0);

        setup("dwr_exit", 8'h89, 0, 3'd0, 3'd3, 1, 1, 0, 16'd1);
        p_cmd(8'h7E); p_ccc(8'h89, 0); estall(); etx(10, 0);
        p_cmd(8'h0B); p_pl(1); p_crc(); p_end(1, 1);
        run(0);

        setup("bcast_01", 8'h01, 0, 3'd0, 3'd2, 0, 0, 0, 16'd1);
        p_cmd(8'h7E); p_ccc(8'h01, 0); p_pl(1); p_crc(); p_end(0, 0);
        run(0);

        // Three payload frames with a defining byte; descriptor scrambled mid-command.
        setup("bcast_3frm", 8'h2A, 0, 3'd0, 3'd5, 1, 1, 1, 16'd3);
        p_cmd(8'h7E); p_ccc(8'h2A, 1); p_pl(3); p_crc(); p_end(1, 1);
        run(1);

        setup("bcast_imm0", 8'h06, 0, 3'd1, 3'd0, 1, 0, 0, 16'd1);
        p_cmd(8'h7E); p_ccc(8'h06, 0); p_crc(); p_end(1, 0);
        run(0);

        // Direct reads use index 31: address byte 8'h3E.
        dev = 5'd31;
        setup("drd_nack", 8'h8D, 1, 3'd0, 3'd2, 0, 0, 0, 16'd2);
        first_pre = 1'b0;
        p_cmd(8'h7E); p_ccc(8'h8D, 0); estall(); etx(10, 0);
        p_cmd(8'h3E); erx(0, 0, 0); cur_err = 4'd4; etx(11, 0); edone(1);
        run(0);

        setup("drd_2frm", 8'h8D, 1, 3'd0, 3'd4, 1, 0, 0, 16'd2);
        p_cmd(8'h7E); p_ccc(8'h8D, 0); estall(); etx(10, 0);
        p_cmd(8'h3E); erx(0, 0, 0); erx(1, 0, 1); erx(1, 1, 1); erx(2, 0, 0); p_end(1, 0);
        run(0);

        setup("drd_short", 8'h8D, 1, 3'd0, 3'd4, 0, 0, 0, 16'd2);
        second_pre = 1'b0; sre = 1'b1;
        p_cmd(8'h7E); p_ccc(8'h8D, 0); estall(); etx(10, 0);
        p_cmd(8'h3E); erx(0, 0, 0); erx(1, 0, 1); cur_err = 4'd5; erx(2, 0, 0); p_end(0, 1);
        run(0);

        // RX error at bit 16; ERROR holds through bits 17..19, resync at 19.
        setup("drd_rxerr", 8'h8D, 1, 3'd0, 3'd4, 0, 0, 0, 16'd2);
        inj_err = 1'b1;
        p_cmd(8'h7E); p_ccc(8'h8D, 0); estall(); etx(10, 0);
        p_cmd(8'h3E); erx(0, 0, 0); erx(1, 0, 0);
        cur_err = 4'd1; eerr(0); eerr(0); eerr(1); etx(11, 0); edone(1);
        run(0);

        // Reset during the command header returns straight to idle.
        setup("mid_reset", 8'h01, 0, 3'd0, 3'd1, 0, 0, 0, 16'd1);
        p_cmd(8'h7E);
        step = 0;
        @(negedge clk);
        en = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle("mid_reset");
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL mid_reset leftover: got %0d unconsumed expected cycles, required 0", exp_q.size());
            exp_q.delete();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ccc_handler.md
# ccc_handler

HDR-DDR Common Command Code (CCC) engine of the I3C controller. When enabled by the main controller, it frames one CCC command descriptor taken from the register file. Broadcast CCCs (CMD[7]=0) and direct CCCs (CMD[7]=1) are both supported. The engine drives the TX/RX serializers, SCL staller, bit counter and frame counter, and reports completion and error status. It sits beside the other HDR engines under the HDR controller mux.

## Interface
- No parameters.
- i_sys_clk  in  1  system clock (50 MHz); all logic on rising edge.
- i_sys_rst  in  1  asynchronous active-low reset.
- i_engine_en  in  1  start/keep engine active; deasserting returns to IDLE next cycle.
- i_bitcnt_number  in  6  current bit index from bit counter.
- i_tx_mode_done  in  1  TX finished current mode.
- i_rx_mode_done  in  1  RX finished current mode.
- i_rx_first_pre  in  1  received first preamble bit; 1 = target ACK.
- i_rx_second_pre  in  1  received second preamble bit; 1 = more data, 0 = target ends read.
- i_rx_error  in  1  RX parity/CRC error.
- i_sclstall_stall_done  in  1  requested SCL stall complete.
- i_frmcnt_last_frame  in  1  current payload frame is the last.
- i_regf_RnW  in  1  0 write, 1 read (direct CCC only).
- i_regf_CMD_ATTR  in  3  0 regular, 1 immediate (payload taken from descriptor, not data buffer).
- i_regf_CMD  in  8  CCC code; bit 7 selects direct.
- i_regf_DEV_INDEX  in  5  target device index.
- i_regf_TOC  in  1  1 = last descriptor, end with EXIT; 0 = end with RESTART.
- i_regf_WROC  in  1  write response on completion.
- i_regf_DTT  in  3  payload byte count (immediate) or defining-byte count.
- i_regf_DBP  in  1  defining byte present.
- i_regf_SRE  in  1  short read is an error.
- o_sclstall_en  out  1  SCL stall request.
- o_sclstall_code  out  4  stall length code.
- o_tx_en  out  1  TX enable.
- o_tx_mode  out  4  TX mode code.
- o_rx_en  out  1  RX enable.
- o_rx_mode  out  3  RX mode code.
- o_bitcnt_en  out  1  bit counter enable.
- o_bitcnt_err_rst  out  1  bit counter resync pulse.
- o_frmcnt_en  out  1  frame counter enable.
- o_sdahand_pp_od  out  1  1 push-pull, 0 open-drain.
- o_regf_wr_en  out  1  register-file write strobe.
- o_regf_rd_en  out  1  register-file read strobe.
- o_regf_addr  out  16  register-file address.
- o_engine_done  out  1  one-cycle completion pulse.
- o_txrx_addr_ccc  out  8  byte presented to TX (address / CCC code).
- o_engine_odd  out  1  1 when the payload byte count is odd.
- o_regf_ERR_STATUS  out  4  0 OK, 1 RX error, 4 NACK, 5 short read.

## Operation
- Moore FSM. Each TX/RX state asserts en plus its mode code and advances on the first cycle where the matching *_mode_done=1.
- TX mode codes: 0 PREAMBLE_CMD, 1 ZERO, 2 SEVEN_ZEROS, 3 ADDR_CCC (o_txrx_addr_ccc), 4 PARITY, 5 PREAMBLE_DATA, 6 REG_DATA, 7 CRC_PREAMBLE, 8 CRC_TOKEN, 9 CRC_VALUE, 10 RESTART, 11 EXIT.
- RX mode codes: 0 PREAMBLE, 1 DATA, 2 CRC.
- Broadcast flow: IDLE → PRE_CMD → RNW(ZERO) → RESERVED(SEVEN_ZEROS) → BCAST_ADDR (o_txrx_addr_ccc=8'h7E) → PARITY → PRE_DATA → CCC_VALUE (=CMD) → DEF_BYTE (only if DBP) → PARITY.
- Payload: loop PRE_DATA → REG_DATA → PARITY, with o_frmcnt_en=1, until i_frmcnt_last_frame=1. The loop is skipped when DTT=0 and CMD_ATTR=1.
- End of broadcast: CRC_PRE → CRC_TOKEN → CRC_VALUE → STALL → RESTART (TOC=0) or EXIT (TOC=1) → DONE.
- Direct flow: after the CCC word, go STALL → RESTART → second command word with RnW=i_regf_RnW, 8'h7E replaced by {DEV_INDEX-mapped address, parity}.
  - Write: payload loop, then CRC.
  - Read: RX PREAMBLE. If first_pre=0, the read is NACKed: ERR=4 and the flow goes to EXIT. Otherwise RX DATA, with o_regf_wr_en on each rx_mode_done. Repeat while second_pre=1 and not last frame. If second_pre=0 before the last frame and SRE=1, ERR=5. Finish with RX CRC.
- o_regf_rd_en pulses one cycle on entry to REG_DATA.
- o_regf_addr = 16'd0 + frame index; the index resets in IDLE.
- STALL: o_sclstall_en=1, o_sclstall_code=4'd2; wait for i_sclstall_stall_done.
- i_rx_error in any RX state → ERROR: ERR=1. Hold until i_bitcnt_number==6'd19, then pulse o_bitcnt_err_rst and go to EXIT.
- DONE: o_engine_done=1 for one cycle. ERR_STATUS is written to regf if WROC=1 or ERR≠0. Then IDLE.
- o_bitcnt_en=1 and o_sdahand_pp_od=1 in every non-IDLE state.
- o_engine_odd = DTT[0] latched at start.

## Timing
- Reset: all outputs 0, state IDLE, ERR=0.
- Latency: IDLE→PRE_CMD one cycle after i_engine_en=1.
- Each state lasts ≥1 cycle; with done held high, each state lasts exactly 1 cycle.
- Descriptor fields are latched in IDLE→PRE_CMD; later input changes take effect only in the next command.
- Simultaneous rx_error and rx_mode_done: the error wins.
- Reset mid-operation: immediate return to IDLE with outputs 0.

## Test plan
- Reset pulse → all outputs 0, state IDLE.
- CMD=8'h89, RnW=0, DTT=2, TOC=0, all done inputs held 1 → full direct-write sequence; RESTART (mode 10) before DONE; o_engine_done pulses once.
- Same but TOC=1 → EXIT (mode 11) replaces RESTART.
- CMD=8'h01 broadcast, last_frame=1 → o_txrx_addr_ccc=8'h7E then 8'h01; exactly one REG_DATA; o_frmcnt_en high only in the payload.
- Direct read with first_pre=0 → ERR_STATUS=4, EXIT, DONE.
- rx_error during RX DATA → ERR=1; o_bitcnt_err_rst pulses at bitcnt 19.
